// File: rtl/reg_alu_sequencer.sv
// Instruction sequencer for a small register/ALU datapath: fetches 24-bit words,
// drives decoded control fields, and handles conditional branches on a captured zero flag.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | out of reset, waiting for start
// FETCH   | imem_req high, waiting for imem_ack
// EXEC    | one cycle: write strobe / branch resolve / retire count
// HALTED  | HALT executed, waiting for start to rerun from address 0
module reg_alu_sequencer #(
    parameter int AW = 8
) (
    input  logic          CLK,
    input  logic          nRESET,
    input  logic          start,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_ack,
    input  logic [23:0]   imem_rdata,
    output logic [3:0]    RA1,
    output logic [3:0]    RA2,
    output logic [3:0]    WA,
    output logic [7:0]    immediate,
    output logic [1:0]    ALUControl,
    output logic          ALUSrc,
    output logic          write_enable,
    input  logic          Zero,
    output logic          busy,
    output logic          halted,
    output logic [AW-1:0] pc,
    output logic [15:0]   retired
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FETCH  = 2'd1,
        S_EXEC   = 2'd2,
        S_HALTED = 2'd3
    } state_t;

    localparam logic [1:0] CLS_ALU_REG = 2'b00;
    localparam logic [1:0] CLS_ALU_IMM = 2'b01;
    localparam logic [1:0] CLS_BZ      = 2'b10;
    localparam logic [1:0] CLS_HALT    = 2'b11;

    state_t        state;
    state_t        state_nxt;
    logic [23:0]   ir;
    logic          zero_flag;
    logic [AW-1:0] pc_q;
    logic [15:0]   retired_q;
    logic [AW-1:0] bz_target;
    logic [1:0]    ir_class;
    logic          launch;
    logic          accept;

    assign ir_class   = ir[23:22];
    assign ALUControl = ir[21:20];
    assign WA         = ir[19:16];
    assign RA1        = ir[15:12];
    assign RA2        = ir[11:8];
    assign immediate  = ir[7:0];
    assign ALUSrc     = ir_class[0];

    assign pc         = pc_q;
    assign imem_addr  = pc_q;
    assign retired    = retired_q;

    // Branch target is the immediate resized to the program-counter width.
    generate
        if (AW > 8) begin : g_tgt_wide
            assign bz_target = {{(AW-8){1'b0}}, ir[7:0]};
        end else if (AW == 8) begin : g_tgt_exact
            assign bz_target = ir[7:0];
        end else begin : g_tgt_narrow
            assign bz_target = ir[AW-1:0];
        end
    endgenerate

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        launch       = 1'b0;
        accept       = 1'b0;
        imem_req     = 1'b0;
        write_enable = 1'b0;
        busy         = 1'b0;
        halted       = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    launch    = 1'b1;
                    state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                busy     = 1'b1;
                imem_req = 1'b1;
                if (imem_ack) begin
                    accept    = 1'b1;
                    state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                busy         = 1'b1;
                write_enable = (ir_class == CLS_ALU_REG) || (ir_class == CLS_ALU_IMM);
                state_nxt    = (ir_class == CLS_HALT) ? S_HALTED : S_FETCH;
            end
            S_HALTED: begin
                halted = 1'b1;
                if (start) begin
                    launch    = 1'b1;
                    state_nxt = S_FETCH;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            ir <= 24'h0;
        end else if (accept) begin
            ir <= imem_rdata;
        end
    end

    // Only ALU-class instructions update the flag; BZ tests whatever the last ALU op left.
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            zero_flag <= 1'b0;
        end else if (state == S_EXEC && !ir_class[1]) begin
            zero_flag <= Zero;
        end
    end

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            pc_q <= '0;
        end else if (launch) begin
            pc_q <= '0;
        end else if (state == S_EXEC) begin
            case (ir_class)
                CLS_ALU_REG, CLS_ALU_IMM: pc_q <= pc_q + 1'b1;
                CLS_BZ:                   pc_q <= zero_flag ? bz_target : pc_q + 1'b1;
                default:                  pc_q <= pc_q;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            retired_q <= 16'h0;
        end else if (launch) begin
            retired_q <= 16'h0;
        end else if (state == S_EXEC && retired_q != 16'hFFFF) begin
            retired_q <= retired_q + 16'd1;
        end
    end

endmodule

// File: tb/tb_reg_alu_sequencer.sv
// Directed bench for reg_alu_sequencer: behavioural instruction memory with
// programmable ack latency, hand-computed expectations checked by immediate assertions.
module tb_reg_alu_sequencer;

    logic        CLK;
    logic        nRESET;
    logic        start;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack;
    logic [23:0] imem_rdata;
    logic [3:0]  RA1;
    logic [3:0]  RA2;
    logic [3:0]  WA;
    logic [7:0]  immediate;
    logic [1:0]  ALUControl;
    logic        ALUSrc;
    logic        write_enable;
    logic        Zero;
    logic        busy;
    logic        halted;
    logic [7:0]  pc;
    logic [15:0] retired;

    reg_alu_sequencer #(.AW(8)) dut (
        .CLK(CLK), .nRESET(nRESET), .start(start),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .RA1(RA1), .RA2(RA2), .WA(WA), .immediate(immediate), .ALUControl(ALUControl),
        .ALUSrc(ALUSrc), .write_enable(write_enable), .Zero(Zero),
        .busy(busy), .halted(halted), .pc(pc), .retired(retired)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic [23:0] mem [256];
    int ack_delay;
    int wait_cnt;
    int we_count;
    logic [3:0] we_wa;
    logic [7:0] we_imm;
    logic       we_alusrc;
    int n_checks;
    int n_fail;

    // Memory responder: ack after ack_delay FETCH cycles, changes only on the falling edge.
    initial begin
        imem_ack   = 1'b0;
        imem_rdata = 24'h0;
        wait_cnt   = 0;
        forever begin
            @(negedge CLK);
            if (imem_req) begin
                if (wait_cnt >= ack_delay) begin
                    imem_ack   = 1'b1;
                    imem_rdata = mem[imem_addr];
                end else begin
                    imem_ack = 1'b0;
                end
                wait_cnt++;
            end else begin
                imem_ack = 1'b0;
                wait_cnt = 0;
            end
        end
    end

    initial begin
        we_count  = 0;
        we_wa     = 4'h0;
        we_imm    = 8'h0;
        we_alusrc = 1'b0;
        forever begin
            @(negedge CLK);
            if (write_enable) begin
                we_count++;
                we_wa     = WA;
                we_imm    = immediate;
                we_alusrc = ALUSrc;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic wait_halt(input int budget);
        int n;
        n = 0;
        while (!halted && n < budget) begin
            step(1);
            n++;
        end
        check("halt_reached", {31'b0, halted}, 32'd1);
    endtask

    int we_base;

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        ack_delay = 0;
        nRESET    = 1'b0;
        start     = 1'b0;
        Zero      = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 24'h0;

        // Reset values before any clock edge
        #1;
        check("rst_busy",    {31'b0, busy}, 32'd0);
        check("rst_halted",  {31'b0, halted}, 32'd0);
        check("rst_req",     {31'b0, imem_req}, 32'd0);
        check("rst_we",      {31'b0, write_enable}, 32'd0);
        check("rst_pc",      {24'b0, pc}, 32'd0);
        check("rst_retired", {16'b0, retired}, 32'd0);
        step(2);
        nRESET = 1'b1;
        step(1);

        // ALU-imm then HALT, immediate ack
        mem[0] = 24'h410005;
        mem[1] = 24'hC00000;
        we_base = we_count;
        pulse_start();
        check("t1_busy", {31'b0, busy}, 32'd1);
        check("t1_req",  {31'b0, imem_req}, 32'd1);
        step(3);
        check("t1_not_halted_yet", {31'b0, halted}, 32'd0);
        step(1);
        check("t1_halted",  {31'b0, halted}, 32'd1);
        check("t1_we_cnt",  we_count - we_base, 32'd1);
        check("t1_we_wa",   {28'b0, we_wa}, 32'd1);
        check("t1_we_imm",  {24'b0, we_imm}, 32'd5);
        check("t1_we_src",  {31'b0, we_alusrc}, 32'd1);
        check("t1_retired", {16'b0, retired}, 32'd2);
        check("t1_pc",      {24'b0, pc}, 32'd1);

        // Delayed ack, restart from HALTED, start ignored while busy
        mem[0] = 24'h1A3456;
        mem[1] = 24'hC00000;
        ack_delay = 3;
        pulse_start();
        check("t2_restart_pc",      {24'b0, pc}, 32'd0);
        check("t2_restart_retired", {16'b0, retired}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            check("t2_req_held",  {31'b0, imem_req}, 32'd1);
            check("t2_addr_held", {24'b0, imem_addr}, 32'd0);
            check("t2_no_we",     {31'b0, write_enable}, 32'd0);
            step(1);
        end
        check("t2_exec_req", {31'b0, imem_req}, 32'd0);
        check("t2_exec_we",  {31'b0, write_enable}, 32'd1);
        check("t2_exec_wa",  {28'b0, WA}, 32'hA);
        check("t2_exec_src", {31'b0, ALUSrc}, 32'd0);
        check("t2_exec_op",  {30'b0, ALUControl}, 32'd1);
        step(1);
        pulse_start();
        check("t2_busy_start_busy",    {31'b0, busy}, 32'd1);
        check("t2_busy_start_pc",      {24'b0, pc}, 32'd1);
        check("t2_busy_start_retired", {16'b0, retired}, 32'd1);
        wait_halt(40);
        check("t2_retired", {16'b0, retired}, 32'd2);
        check("t2_pc",      {24'b0, pc}, 32'd1);

        // BZ taken / not taken
        ack_delay = 0;
        mem[0]    = 24'h020000;
        mem[1]    = 24'h800020;
        mem[2]    = 24'hC00000;
        mem[32]   = 24'hC00000;
        Zero = 1'b1;
        pulse_start();
        wait_halt(20);
        check("t3_taken_pc",      {24'b0, pc}, 32'h20);
        check("t3_taken_retired", {16'b0, retired}, 32'd3);
        Zero = 1'b0;
        pulse_start();
        wait_halt(20);
        check("t3_fall_pc",      {24'b0, pc}, 32'd2);
        check("t3_fall_retired", {16'b0, retired}, 32'd3);

        // Wrap from 0xFF, then asynchronous reset in the middle of an ALU EXEC
        mem[0]   = 24'h1A3456;
        mem[1]   = 24'h8000FF;
        mem[255] = 24'h4F00AA;
        Zero = 1'b1;
        pulse_start();
        step(4);
        check("t4_addr_ff", {24'b0, imem_addr}, 32'hFF);
        step(1);
        check("t4_ff_we",  {31'b0, write_enable}, 32'd1);
        check("t4_ff_wa",  {28'b0, WA}, 32'hF);
        check("t4_ff_imm", {24'b0, immediate}, 32'hAA);
        check("t4_ff_src", {31'b0, ALUSrc}, 32'd1);
        step(1);
        check("t4_wrap_addr",    {24'b0, imem_addr}, 32'd0);
        check("t4_wrap_req",     {31'b0, imem_req}, 32'd1);
        check("t4_wrap_retired", {16'b0, retired}, 32'd3);
        step(1);
        check("t5_pre_we", {31'b0, write_enable}, 32'd1);
        #2;
        nRESET = 1'b0;
        #1;
        check("t5_we",      {31'b0, write_enable}, 32'd0);
        check("t5_req",     {31'b0, imem_req}, 32'd0);
        check("t5_busy",    {31'b0, busy}, 32'd0);
        check("t5_halted",  {31'b0, halted}, 32'd0);
        check("t5_pc",      {24'b0, pc}, 32'd0);
        check("t5_retired", {16'b0, retired}, 32'd0);
        check("t5_ir_wa",   {28'b0, WA}, 32'd0);
        check("t5_ir_imm",  {24'b0, immediate}, 32'd0);
        we_base = we_count;
        step(2);
        check("t5_no_we_in_reset", we_count - we_base, 32'd0);
        nRESET = 1'b1;
        step(1);

        // Zero flag cleared by reset: BZ from IDLE falls through
        mem[0] = 24'h800040;
        mem[1] = 24'hC00000;
        pulse_start();
        wait_halt(20);
        check("t6_pc",      {24'b0, pc}, 32'd1);
        check("t6_retired", {16'b0, retired}, 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_alu_sequencer.md
REG_ALU_SEQUENCER -- requirements
Module: reg_alu_sequencer

Interface
REQ-001 SHALL have parameter AW, default 8, meaning the program-counter and instruction-address width in bits.
REQ-002 SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port nRESET, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port start, input, 1 bit: begin execution at address 0 (sampled in IDLE/HALTED only).
REQ-005 SHALL have port imem_req, output, 1 bit: instruction fetch request.
REQ-006 SHALL have port imem_addr, output, AW bits: fetch address, equal to pc.
REQ-007 SHALL have port imem_ack, input, 1 bit: imem_rdata valid for the current request.
REQ-008 SHALL have port imem_rdata, input, 24 bits: instruction word.
REQ-009 SHALL have ports RA1, RA2 and WA, each output, 4 bits: datapath register addresses.
REQ-010 SHALL have port immediate, output, 8 bits: datapath immediate.
REQ-011 SHALL have port ALUControl, output, 2 bits: datapath ALU operation.
REQ-012 SHALL have port ALUSrc, output, 1 bit: datapath B-operand select (1 = immediate).
REQ-013 SHALL have port write_enable, output, 1 bit: datapath register-file write strobe.
REQ-014 SHALL have port Zero, input, 1 bit: datapath ALU zero result.
REQ-015 SHALL have ports busy and halted, each output, 1 bit: status.
REQ-016 SHALL have port pc, output, AW bits: current program counter.
REQ-017 SHALL have port retired, output, 16 bits: count of completed instructions.

Function
REQ-018 SHALL decode the instruction format as [23:22] class (00 ALU-reg, 01 ALU-imm, 10 BZ, 11 HALT), [21:20] ALUControl, [19:16] WA, [15:12] RA1, [11:8] RA2, [7:0] immediate.
REQ-019 SHALL implement a state machine with states IDLE, FETCH, EXEC and HALTED.
REQ-020 SHALL transition IDLE->FETCH and HALTED->FETCH on start=1, clearing pc to 0 and retired to 0.
REQ-021 SHALL assert imem_req only in FETCH, held high until imem_ack; an ack arriving in the first FETCH cycle SHALL be accepted.
REQ-022 SHALL latch imem_rdata into the instruction register on the FETCH cycle with imem_ack=1 and move to EXEC; imem_ack outside FETCH SHALL be ignored.
REQ-023 SHALL drive RA1, RA2, WA, immediate and ALUControl from the instruction register at all times, with ALUSrc = class[0].
REQ-024 SHALL assert write_enable for exactly the one EXEC cycle of ALU-reg and ALU-imm instructions, and never otherwise.
REQ-025 SHALL capture Zero into an internal zero flag at the end of each ALU-class EXEC cycle; BZ and HALT SHALL leave the flag unchanged.
REQ-026 SHALL, in EXEC for BZ, load pc with immediate[AW-1:0] if the zero flag is 1, else pc+1.
REQ-027 SHALL, in EXEC for ALU classes, load pc with pc+1, wrapping from 2^AW-1 to 0.
REQ-028 SHALL, in EXEC, move to FETCH for ALU and BZ classes and to HALTED for HALT (pc unchanged).
REQ-029 SHALL increment retired by one on every EXEC cycle including HALT, saturating at 16'hFFFF.
REQ-030 SHALL drive busy = 1 in FETCH/EXEC, halted = 1 in HALTED, and otherwise 0.
REQ-031 SHALL ignore start while busy=1.
REQ-032 SHALL give a minimum of 2 cycles per instruction (FETCH with immediate ack, then EXEC).

Reset
REQ-033 SHALL, while nRESET=0 regardless of CLK, force state IDLE, pc=0, retired=0, zero flag=0, instruction register=0, imem_req=0, write_enable=0, busy=0 and halted=0.
REQ-034 SHALL, on reset asserted mid-FETCH or mid-EXEC, abandon the instruction with no write_enable pulse after reset assertion.

Verification
REQ-035 SHALL pass: start with mem[0]=0x4_0_1_0_05 (ALU-imm, WA=1, imm=5) and mem[1]=0xC00000, acked immediately -> one write_enable pulse with ALUSrc=1, WA=1, immediate=5; halted=1 after 4 cycles; retired=2; pc=1.
REQ-036 SHALL pass: imem_ack delayed 3 cycles -> imem_req held 4 cycles, imem_addr stable, no write_enable until EXEC.
REQ-037 SHALL pass: ALU op with Zero=1 then BZ imm=0x20 -> pc=0x20; repeat with Zero=0 -> pc=previous+1.
REQ-038 SHALL pass: pc=0xFF executing an ALU op -> next fetch address 0x00.
REQ-039 SHALL pass: nRESET pulled low between clock edges during EXEC -> outputs at reset values immediately, write_enable=0, state IDLE.
REQ-040 SHALL pass: start pulsed while busy -> no effect on pc or retired; start while halted -> restart at address 0 with retired=0.
